// File: rtl/tx_frame_scheduler_pkg.sv
// tx_frame_scheduler shared types: FSM state encoding, default widths and a
// small index-width helper used by the interface, the arbiter and the top.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = 8;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Producer/transmitter bundle for tx_frame_scheduler.
// slave  : the scheduler's view (samples requests and tx_done, drives grants).
// master : the surrounding system's view (producers plus transmitter).
interface tx_frame_scheduler_if
    import tx_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DEFAULT_DATA_W
);
    localparam int IDX_W = idx_width(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_done;
    logic                    busy;
    logic [IDX_W-1:0]        grant_idx;
    logic                    tx_err;

    modport master (
        output req, req_data, tx_done,
        input  grant, tx_start, tx_data, busy, grant_idx, tx_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output grant, tx_start, tx_data, busy, grant_idx, tx_err
    );

endinterface

// File: rtl/tx_frame_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector. The search starts one past
// ptr (the last winner) and wraps modulo N_REQ; implemented as rotate,
// lowest-set-bit priority encode, then un-rotate of the found offset.
module rr_pick
    import tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    localparam int unsigned N_U = N_REQ;

    logic [N_REQ-1:0] rot;
    int unsigned      start;
    int unsigned      offset;
    logic             found;

    // Rotate req so the slot after ptr sits at bit 0, encode, rotate back.
    always_comb begin
        start  = (32'(ptr) + 32'd1) % N_U;
        rot    = '0;
        found  = 1'b0;
        offset = 0;
        for (int unsigned i = 0; i < N_U; i++) begin
            rot[IDX_W'(i)] = req[IDX_W'((start + i) % N_U)];
        end
        for (int unsigned i = 0; i < N_U; i++) begin
            if (!found && rot[IDX_W'(i)]) begin
                found  = 1'b1;
                offset = i;
            end
        end
        valid = found;
        idx   = IDX_W'((start + offset) % N_U);
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: shares one serial transmitter among N_REQ producers.
// Round-robin grant, one-cycle tx_start, wait for tx_done, then an
// inter-frame gap of GAP_CYCLES before the next arbitration.
// Optional macro TX_SCHED_TIMEOUT_EN adds a WAIT_DONE watchdog that pulses
// tx_err after TIMEOUT_CYCLES without tx_done; otherwise tx_err is tied 0.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int GAP_CYCLES     = 16,
    parameter int CNT_W          = DEFAULT_CNT_W,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_frame_scheduler_if.slave  bus
);
    localparam int IDX_W = idx_width(N_REQ);
    localparam logic [CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
`ifdef TX_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
`endif

    if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 0 || GAP_CYCLES >= (1 << CNT_W) ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("tx_frame_scheduler: parameter out of range");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [N_REQ-1:0]  grant_q;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              busy_q;
    logic [IDX_W-1:0]  grant_idx_q;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (grant_idx_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef TX_SCHED_TIMEOUT_EN
    logic tx_err_q;

    // Frame sequencer with watchdog: tx_done on the expiry cycle wins over tx_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            grant_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            grant_idx_q <= IDX_W'(N_REQ - 1);
            tx_err_q    <= 1'b0;
        end else begin
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx_q       <= pick_idx;
                        tx_data_q         <= bus.req_data[32'(pick_idx) * DATA_W +: DATA_W];
                        grant_q[pick_idx] <= 1'b1;
                        tx_start_q        <= 1'b1;
                        busy_q            <= 1'b1;
                        state             <= START;
                    end
                end
                START: begin
                    cnt   <= TIMEOUT_LOAD;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.tx_done || cnt == '0) begin
                        tx_err_q <= !bus.tx_done;
                        if (GAP_CYCLES == 0) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_err = tx_err_q;
`else
    // Frame sequencer: arbitrate, launch, wait indefinitely for tx_done, gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            grant_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            grant_idx_q <= IDX_W'(N_REQ - 1);
        end else begin
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx_q       <= pick_idx;
                        tx_data_q         <= bus.req_data[32'(pick_idx) * DATA_W +: DATA_W];
                        grant_q[pick_idx] <= 1'b1;
                        tx_start_q        <= 1'b1;
                        busy_q            <= 1'b1;
                        state             <= START;
                    end
                end
                START: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        if (GAP_CYCLES == 0) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_err = 1'b0;
`endif

    assign bus.grant     = grant_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_idx = grant_idx_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler: a timeline model (cycle numbers
// of launch, done and next-arbitration) checks every output on every cycle,
// directed sequences pin literal expectations, then randomized traffic runs.
module tb_tx_frame_scheduler;
    localparam int N          = 4;
    localparam int DW         = 8;
    localparam int TB_GAP     = 16;
    localparam int TB_CNT_W   = 8;
    localparam int TB_TIMEOUT = 10;
`ifdef TX_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    tx_frame_scheduler_if #(.N_REQ(N), .DATA_W(DW)) bus();

    tx_frame_scheduler #(
        .N_REQ          (N),
        .DATA_W         (DW),
        .GAP_CYCLES     (TB_GAP),
        .CNT_W          (TB_CNT_W),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timeline arithmetic) ----------------
    int            cyc = 0;
    bit            m_inflight;
    int            m_idle_from;   // first edge at which arbitration may happen
    int            m_start;       // edge that launched the current frame
    int            m_last;        // most recent winner
    logic [DW-1:0] m_data;
    logic [N-1:0]  exp_grant;
    bit            exp_start, exp_err, exp_busy;

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_inflight  = 1'b0;
        m_idle_from = 0;
        m_start     = -100;
        m_last      = N - 1;
        m_data      = '0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_reset();
        end else begin
            exp_grant = '0;
            exp_start = 1'b0;
            exp_err   = 1'b0;
            if (!m_inflight) begin
                if (cyc >= m_idle_from && bus.req != '0) begin
                    m_last       = pick(bus.req, m_last);
                    m_data       = bus.req_data[m_last*DW +: DW];
                    m_inflight   = 1'b1;
                    m_start      = cyc;
                    exp_start    = 1'b1;
                    exp_grant[m_last] = 1'b1;
                end
            end else if (cyc >= m_start + 2) begin
                if (bus.tx_done) begin
                    m_inflight  = 1'b0;
                    m_idle_from = cyc + TB_GAP + 1;
                end else if (TO_EN && cyc == m_start + 1 + TB_TIMEOUT) begin
                    m_inflight  = 1'b0;
                    m_idle_from = cyc + TB_GAP + 1;
                    exp_err     = 1'b1;
                end
            end
            exp_busy = m_inflight || (cyc + 1 < m_idle_from);
            #1;
            check("grant",     32'(bus.grant),     32'(exp_grant));
            check("tx_start",  32'(bus.tx_start),  32'(exp_start));
            check("tx_data",   32'(bus.tx_data),   32'(m_data));
            check("busy",      32'(bus.busy),      32'(exp_busy));
            check("grant_idx", 32'(bus.grant_idx), 32'(m_last));
            check("tx_err",    32'(bus.tx_err),    32'(exp_err));
        end
        cyc++;
    end

    // ---------------- directed helpers ----------------
    task automatic wait_start(output int idx);
        bit ok;
        ok  = 1'b0;
        idx = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (bus.tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("start_seen", 32'(ok), 32'd1);
        for (int i = 0; i < N; i++) if (bus.grant[i]) idx = i;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            if (!bus.busy) break;
            @(posedge clk); #1;
        end
        check("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic finish_frame();
        repeat (2) @(negedge clk);
        pulse_done();
        wait_idle();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst         = 1'b1;
        bus.req     = '0;
        bus.tx_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int idx, kb, ks, cnt;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_done  = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_grant",     32'(bus.grant),     32'd0);
        check("rst_tx_start",  32'(bus.tx_start),  32'd0);
        check("rst_tx_data",   32'(bus.tx_data),   32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_tx_err",    32'(bus.tx_err),    32'd0);
        check("rst_grant_idx", 32'(bus.grant_idx), 32'd3);

        // Single requester, launch latency and gap length.
        @(negedge clk);
        bus.req      = 4'b0001;
        bus.req_data = {24'h123456, 8'hA5};
        wait_start(idx);
        check("t1_grant",   32'(bus.grant),   32'h1);
        check("t1_tx_data", 32'(bus.tx_data), 32'hA5);
        check("t1_busy",    32'(bus.busy),    32'd1);
        @(negedge clk);
        bus.req = '0;
        repeat (3) @(negedge clk);
        pulse_done();
        bus.req = 4'b0001;
        kb = -1;
        ks = -1;
        for (int k = 0; k < 60; k++) begin
            if (kb < 0 && !bus.busy) kb = k;
            if (bus.tx_start) begin
                ks = k;
                break;
            end
            bus.tx_done = (k == 4);
            @(posedge clk); #1;
        end
        bus.tx_done = 1'b0;
        check("busy_fall_after_done", 32'(kb), 32'(TB_GAP));
        check("restart_after_done",   32'(ks), 32'(TB_GAP + 1));
        @(negedge clk);
        bus.req = '0;
        finish_frame();

        // tx_done while idle must not launch anything.
        pulse_done();
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.tx_start) cnt++;
        end
        check("idle_done_no_start", 32'(cnt), 32'd0);

        // Move the pointer to 1, then 1010 wraps: 3 first, then 1.
        @(negedge clk);
        bus.req = 4'b0010;
        wait_start(idx);
        check("ptr_to_1", 32'(idx), 32'd1);
        @(negedge clk);
        bus.req = 4'b1010;
        finish_frame();
        wait_start(idx);
        check("wrap_first",     32'(idx),           32'd3);
        check("wrap_first_idx", 32'(bus.grant_idx), 32'd3);
        finish_frame();
        wait_start(idx);
        check("wrap_second", 32'(idx), 32'd1);
        @(negedge clk);
        bus.req = '0;
        finish_frame();

        // Asynchronous reset during WAIT_DONE.
        @(negedge clk);
        bus.req = 4'b0100;
        wait_start(idx);
        check("pre_rst_grant", 32'(idx), 32'd2);
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_grant",     32'(bus.grant),     32'd0);
        check("arst_tx_start",  32'(bus.tx_start),  32'd0);
        check("arst_tx_data",   32'(bus.tx_data),   32'd0);
        check("arst_busy",      32'(bus.busy),      32'd0);
        check("arst_tx_err",    32'(bus.tx_err),    32'd0);
        check("arst_grant_idx", 32'(bus.grant_idx), 32'd3);
        @(negedge clk);
        rst     = 1'b0;
        bus.req = 4'b0100;
        wait_start(idx);
        check("post_rst_grant",     32'(idx),           32'd2);
        check("post_rst_grant_idx", 32'(bus.grant_idx), 32'd2);
        @(negedge clk);
        bus.req = '0;
        finish_frame();

        // All requesting: strict rotation 0,1,2,3,0 from reset.
        reset_dut();
        @(negedge clk);
        bus.req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_start(idx);
            check("rr_order",     32'(idx),           32'(f % 4));
            check("rr_grant_idx", 32'(bus.grant_idx), 32'(f % 4));
            if (f == 4) begin
                @(negedge clk);
                bus.req = '0;
            end
            finish_frame();
        end

`ifdef TX_SCHED_TIMEOUT_EN
        // Watchdog expiry, then tx_done exactly on the expiry cycle.
        @(negedge clk);
        bus.req = 4'b0001;
        wait_start(idx);
        @(negedge clk);
        bus.req = '0;
        ks = -1;
        for (int k = 1; k <= 3 * TB_TIMEOUT; k++) begin
            @(posedge clk); #1;
            if (bus.tx_err) begin
                ks = k;
                break;
            end
        end
        check("timeout_edge", 32'(ks), 32'(TB_TIMEOUT + 1));
        @(posedge clk); #1;
        check("timeout_one_cycle", 32'(bus.tx_err), 32'd0);
        check("timeout_then_gap",  32'(bus.busy),   32'd1);
        wait_idle();
        @(negedge clk);
        bus.req = 4'b0001;
        wait_start(idx);
        @(negedge clk);
        bus.req = '0;
        repeat (TB_TIMEOUT) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
        check("done_beats_timeout", 32'(bus.tx_err), 32'd0);
        check("done_then_gap",      32'(bus.busy),   32'd1);
        wait_idle();
`else
        // Without the watchdog, WAIT_DONE holds as long as tx_done is absent.
        @(negedge clk);
        bus.req = 4'b0001;
        wait_start(idx);
        @(negedge clk);
        bus.req = '0;
        cnt = 0;
        repeat (3 * TB_TIMEOUT) begin
            @(posedge clk); #1;
            if (bus.tx_err) cnt++;
        end
        check("no_tx_err",     32'(cnt),      32'd0);
        check("still_waiting", 32'(bus.busy), 32'd1);
        finish_frame();
`endif

        // Randomized traffic, spurious tx_done and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            bus.req_data = 32'($urandom);
            bus.tx_done  = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.req     = '0;
        bus.tx_done = 1'b0;
        repeat (5) @(negedge clk);
        pulse_done();
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
